// File: rtl/ex_muldiv_ctrl.sv
// ============================================================================
//  Module   : ex_muldiv_ctrl
//  Purpose  : Iterative MULT/MULTU/DIV/DIVU sequencer beside the EX ALU.
//             Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ex_muldiv_ctrl #(
    parameter logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF,
    parameter int          ITERS      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_flush,
    input  logic [7:0]  i_aluop,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic        o_stall,
    output logic        o_busy,
    output logic        o_hilo_we,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_LAST = 5'(ITERS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic        r_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_a;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;

    // Opcode decode: 0001_10xx, bit1 = divide, bit0 = unsigned
    logic        w_is_md;
    logic        w_issue;
    logic        w_op_div;
    logic        w_op_signed;
    logic        w_rt_zero;
    logic        w_fast;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    assign w_is_md     = (i_aluop[7:2] == 6'b000110);
    assign w_issue     = i_valid && w_is_md && !i_flush;
    assign w_op_div    = i_aluop[1];
    assign w_op_signed = !i_aluop[0];
    assign w_rt_zero   = (i_rt_data == 32'd0);
    assign w_a_neg     = w_op_signed && i_rs_data[31];
    assign w_b_neg     = w_op_signed && i_rt_data[31];
    assign w_abs_a     = w_a_neg ? (32'd0 - i_rs_data) : i_rs_data;
    assign w_abs_b     = w_b_neg ? (32'd0 - i_rt_data) : i_rt_data;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [63:0] w_fast_prod;
    assign w_fast      = !w_op_div;
    assign w_prod_s    = $signed(i_rs_data) * $signed(i_rt_data);
    assign w_prod_u    = {32'd0, i_rs_data} * {32'd0, i_rt_data};
    assign w_fast_prod = w_op_signed ? w_prod_s : w_prod_u;
`else
    assign w_fast      = 1'b0;
`endif

    // Multiply step: {hi,lo} shifts right, adding multiplicand when lo[0] set
    logic [32:0] w_msum;
    // Divide step: 33-bit partial remainder {hi, next dividend bit}
    logic [32:0] w_dshift;
    logic        w_dge;
    logic [31:0] w_dsub;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;

    assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);
    assign w_dshift = {r_hi, r_lo[31]};
    assign w_dge    = (w_dshift >= {1'b0, r_a});
    assign w_dsub   = w_dshift[31:0] - r_a;
    assign w_hi_nxt = r_div ? (w_dge ? w_dsub : w_dshift[31:0]) : w_msum[32:1];
    assign w_lo_nxt = r_div ? {r_lo[30:0], w_dge} : {w_msum[0], r_lo[31:1]};

    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    always_comb begin
        w_prod   = r_neg_q ? (64'd0 - {r_hi, r_lo}) : {r_hi, r_lo};
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_div) begin
            w_res_hi = r_neg_r ? (32'd0 - r_hi) : r_hi;
            w_res_lo = r_neg_q ? (32'd0 - r_lo) : r_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_stall     = 1'b0;
        o_hilo_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    o_stall     = 1'b1;
                    w_state_nxt = ((w_op_div && w_rt_zero) || w_fast) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    o_stall = 1'b1;
                    if (r_cnt == c_LAST) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_hilo_we   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (rst) begin
            o_stall   = 1'b0;
            o_hilo_we = 1'b0;
        end
    end

    assign o_busy = (r_state != S_IDLE) && !rst;
    assign o_hi   = (r_state == S_DONE) ? w_res_hi : r_res_hi;
    assign o_lo   = (r_state == S_DONE) ? w_res_lo : r_res_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_cnt   <= 5'd0;
                        r_div   <= w_op_div;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_hi    <= 32'd0;
                        if (w_op_div) begin
                            r_lo <= w_abs_a;
                            r_a  <= w_abs_b;
                            // Divide-by-zero: HI keeps the raw dividend, no sign fix
                            if (w_rt_zero) begin
                                r_hi    <= i_rs_data;
                                r_lo    <= DIV_ZERO_Q;
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                            end
                        end else begin
                            r_lo <= w_abs_b;
                            r_a  <= w_abs_a;
`ifdef MULDIV_FAST_MUL_EN
                            r_hi    <= w_fast_prod[63:32];
                            r_lo    <= w_fast_prod[31:0];
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
`endif
                        end
                    end
                end
                S_CALC: begin
                    if (!i_flush) begin
                        r_cnt <= r_cnt + 5'd1;
                        r_hi  <= w_hi_nxt;
                        r_lo  <= w_lo_nxt;
                    end
                end
                S_DONE: begin
                    r_res_hi <= w_res_hi;
                    r_res_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
